mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative multiply/divide unit for the CPU datapath; the sequential companion to the single-cycle ALU, covering MIPS `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo`. It holds the HI/LO result registers. It computes one radix-2 step per clock, so area stays small at the cost of a fixed latency. The core stalls on `busy` and reads HI/LO after `done`.

## Interface
- `WIDTH`, default 32: operand width and HI/LO width. Must be at least 2.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: operation request. Sampled only in IDLE.
- `op` input 2: operation select.
  - 00 = mult (signed)
  - 01 = multu
  - 10 = div (signed)
  - 11 = divu
- `a` input WIDTH: multiplicand or dividend (rs).
- `b` input WIDTH: multiplier or divisor (rt).
- `flush` input 1: aborts any operation in progress (pipeline exception).
- `hi_we`, `lo_we` input 1 each: mthi/mtlo write enables.
- `wdata` input WIDTH: data for mthi/mtlo.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse; HI/LO are valid while it is high.
- `dz` output 1: divide-by-zero flag. Valid with `done`, held until the next `done`.
- `hi`, `lo` output WIDTH: result registers.

## Operation
- States are IDLE, CALC and FINISH. The state, a log2(WIDTH)+1-bit step counter, and 2·WIDTH+1-bit working registers are all cleared by reset.
- **IDLE, `start`=1 and `flush`=0:**
  - Latch |a| and |b|. For unsigned ops, or for a non-negative operand, this is the raw value.
  - Latch the result signs: `sq = a[W-1]^b[W-1]` and `sr = a[W-1]`, both forced to 0 for unsigned ops.
  - Clear the counter.
  - Go to CALC, or straight to FINISH if op is a divide and b==0.
- **CALC, multiply:** shift-add. Each step adds |a| into the upper half when the current multiplier LSB is 1, then shifts right one bit.
- **CALC, divide:** restoring. Each step shifts the remainder:quotient pair left, trial-subtracts |b|, and sets the quotient LSB when the difference is non-negative.
- CALC runs exactly WIDTH steps, then moves to FINISH.
- **FINISH**, lasts one cycle:
  - Multiply: the 2W-bit product is negated if `sq`. HI gets the upper half and LO the lower half.
  - Divide: LO gets the quotient, negated if `sq`. HI gets the remainder, negated if `sr`.
  - Divide by zero: HI and LO are unchanged and `dz` is set.
  - Results register on the edge that leaves FINISH. `done`=1 in the following cycle, and the state is IDLE.
- **Signed overflow case:** MIN/−1 gives LO=MIN and HI=0 (W-bit wrap of the quotient). No trap is raised.
- **`dz`** is cleared on every `done` that does not come from a divide by zero.
- **mthi/mtlo:**
  - `hi_we` or `lo_we` writes `wdata` into HI or LO at the clock edge, but only in IDLE.
  - They are ignored while `busy`=1. The core interlocks, so this case does not occur in a correct pipeline.
  - `hi_we`/`lo_we` and `start` in the same cycle: the write happens, and the operation result overwrites it later.
- **`flush`:**
  - In any state, `flush`=1 returns the state to IDLE at the next edge.
  - HI, LO and `dz` are unchanged and no `done` is produced.
  - `flush` has priority over `start`.
- `start` while `busy` is ignored. No queueing.

## Timing
- **Reset values:** `busy`=0, `done`=0, `dz`=0, `hi`=0, `lo`=0, state IDLE. Reset takes effect asynchronously, including mid-operation, and discards the operation.
- **Latency:** call the edge that samples `start` edge 0.
  - `busy`=1 from cycle 1 through cycle WIDTH+1.
  - `done`=1 and `busy`=0 in cycle WIDTH+2, with HI/LO valid.
  - For WIDTH=32, `done` is in cycle 34.
- **Divide by zero:** `busy`=1 in cycle 1 only; `done`=1 and `dz`=1 in cycle 2.
- **Back-to-back:** `start` is accepted in the same cycle that `done` is high.
- **Registered outputs:** `busy` is a registered decode of state ≠ IDLE. `done` is registered. Neither has a combinational path from inputs.
- **Operand capture:** `a`, `b` and `op` are only needed in the `start` cycle and may change afterwards.

## Test plan
- **mult:** WIDTH=32, a=0xFFFFFFFD (−3), b=5 → in cycle 34, `done`=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1, `dz`=0. `busy` is high for cycles 1–33.
- **multu:** a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- **div:** a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Then a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- **divu by zero:** preload hi=0x11, lo=0x22 via mthi/mtlo; divu 7/0 → `done` in cycle 2, `dz`=1, hi=0x11, lo=0x22.
  - A following multu 2×3 → hi=0, lo=6, `dz`=0.
- **Abort:**
  - `flush` in cycle 10 of a mult → `busy`=0 in cycle 11, no `done`, HI/LO unchanged.
  - Repeat with `rst_n` low mid-CALC → all outputs zero immediately.
- **Busy rules and back-to-back:**
  - `start` asserted in cycle 5 of a div is ignored.
  - `hi_we` while busy is ignored.
  - `start` held high continuously yields `done` every 34 cycles, each result correct.

Source files
------------

// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply/divide unit holding the HI/LO registers.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, op[1:0]      request and op select (00 mult, 01 multu, 10 div, 11 divu)
//   a, b                operands, only sampled with start in IDLE
//   flush               abort current operation, no done
//   hi_we, lo_we, wdata mthi/mtlo writes, honoured only in IDLE
//   busy, done, dz      status (registered)
//   hi, lo              result registers
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned AW = 2 * WIDTH + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opr_q, opr_d;     // |a| for multiply, |b| for divide
  logic             is_div_q, is_div_d;
  logic             divz_q, divz_d;
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // operand magnitudes and signs at start
  logic             a_neg_c, b_neg_c;
  logic [WIDTH-1:0] abs_a_c, abs_b_c;
  // one iteration step
  logic [WIDTH:0]   sum_c;
  logic [AW-1:0]    shl_c;
  logic [WIDTH:0]   rem_sh_c;
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0] quot_c, rem_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opr_q    <= '0;
      is_div_q <= 1'b0;
      divz_q   <= 1'b0;
      sq_q     <= 1'b0;
      sr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opr_q    <= opr_d;
      is_div_q <= is_div_d;
      divz_q   <= divz_d;
      sq_q     <= sq_d;
      sr_q     <= sr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opr_d    = opr_q;
    is_div_d = is_div_q;
    divz_d   = divz_q;
    sq_d     = sq_q;
    sr_d     = sr_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    a_neg_c  = ~op[0] & a[WIDTH-1];
    b_neg_c  = ~op[0] & b[WIDTH-1];
    abs_a_c  = a_neg_c ? (~a + WIDTH'(1)) : a;
    abs_b_c  = b_neg_c ? (~b + WIDTH'(1)) : b;

    sum_c    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opr_q};
    shl_c    = acc_q << 1;
    rem_sh_c = shl_c[2*WIDTH:WIDTH];
    prod_c   = sq_q ? (~acc_q[2*WIDTH-1:0] + (2*WIDTH)'(1)) : acc_q[2*WIDTH-1:0];
    quot_c   = sq_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_c    = sr_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_q[2*WIDTH-1:WIDTH];

    // mthi/mtlo; a result in FINISH later overwrites these
    if (state_q == S_IDLE) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            is_div_d = op[1];
            divz_d   = op[1] & (b == '0);
            sq_d     = a_neg_c ^ b_neg_c;
            sr_d     = a_neg_c;
            cnt_d    = '0;
            opr_d    = op[1] ? abs_b_c : abs_a_c;
            acc_d    = {{(WIDTH+1){1'b0}}, (op[1] ? abs_a_c : abs_b_c)};
            state_d  = (op[1] && (b == '0)) ? S_FINISH : S_CALC;
          end
        end
        S_CALC: begin
          if (is_div_q) begin
            // restoring step: shift, trial subtract, set quotient bit
            if (rem_sh_c >= {1'b0, opr_q}) begin
              acc_d = {rem_sh_c - {1'b0, opr_q}, shl_c[WIDTH-1:1], 1'b1};
            end else begin
              acc_d = shl_c;
            end
          end else begin
            // shift-add step; carry lands in the top bit of the upper half
            if (acc_q[0]) acc_d = {1'b0, sum_c, acc_q[WIDTH-1:1]};
            else          acc_d = {1'b0, acc_q[2*WIDTH:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FINISH;
        end
        S_FINISH: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (divz_q) begin
            dz_d = 1'b1;
          end else begin
            dz_d = 1'b0;
            if (is_div_q) begin
              hi_d = rem_c;
              lo_d = quot_c;
            end else begin
              hi_d = prod_c[2*WIDTH-1:WIDTH];
              lo_d = prod_c[WIDTH-1:0];
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed self-checking bench for mdu_iter (WIDTH=32).
module tb_mdu_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a request for one cycle; returns positioned in cycle 1
  task automatic do_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    a = 32'hDEADBEEF; b = 32'hDEADBEEF; op = 2'b00;
  endtask

  // run from cycle c0 until done (bounded); cyc=-1 on timeout, gaps counts non-busy cycles
  task automatic wait_done(input int c0, output int cyc, output int gaps);
    cyc = c0; gaps = 0;
    while (!done && cyc < 100) begin
      if (!busy) gaps++;
      tick();
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic test_reset();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b exp 0", done); else pass_cnt++;
    total_cnt++; if (dz !== 1'b0) $display("FAIL reset_dz: got %b exp 0", dz); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h exp 0", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h exp 0", lo); else pass_cnt++;
  endtask

  task automatic test_mult();
    int cyc, gaps;
    do_start(2'b00, 32'hFFFFFFFD, 32'd5);
    wait_done(1, cyc, gaps);
    total_cnt++; if (cyc !== 34) $display("FAIL mult_latency: got %0d exp 34", cyc); else pass_cnt++;
    total_cnt++; if (gaps !== 0) $display("FAIL mult_busy: got %0d idle cycles exp 0", gaps); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mult_busy_at_done: got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h exp FFFFFFFF", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFFFFF1) $display("FAIL mult_lo: got %h exp FFFFFFF1", lo); else pass_cnt++;
    total_cnt++; if (dz !== 1'b0) $display("FAIL mult_dz: got %b exp 0", dz); else pass_cnt++;
    tick();
    total_cnt++; if (done !== 1'b0) $display("FAIL mult_done_pulse: got %b exp 0", done); else pass_cnt++;
  endtask

  task automatic test_multu();
    int cyc, gaps;
    do_start(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(1, cyc, gaps);
    total_cnt++; if (cyc !== 34) $display("FAIL multu_latency: got %0d exp 34", cyc); else pass_cnt++;
    total_cnt++; if (hi !== 32'hFFFFFFFE) $display("FAIL multu_hi: got %h exp FFFFFFFE", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h00000001) $display("FAIL multu_lo: got %h exp 00000001", lo); else pass_cnt++;
    tick();
  endtask

  task automatic test_div();
    int cyc, gaps;
    do_start(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(1, cyc, gaps);
    total_cnt++; if (cyc !== 34) $display("FAIL div_latency: got %0d exp 34", cyc); else pass_cnt++;
    total_cnt++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_lo: got %h exp FFFFFFFD", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'hFFFFFFFF) $display("FAIL div_hi: got %h exp FFFFFFFF", hi); else pass_cnt++;
    tick();
    do_start(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(1, cyc, gaps);
    total_cnt++; if (cyc !== 34) $display("FAIL div_ovf_latency: got %0d exp 34", cyc); else pass_cnt++;
    total_cnt++; if (lo !== 32'h80000000) $display("FAIL div_ovf_lo: got %h exp 80000000", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0) $display("FAIL div_ovf_hi: got %h exp 00000000", hi); else pass_cnt++;
    tick();
    do_start(2'b11, 32'd100, 32'd7);
    wait_done(1, cyc, gaps);
    total_cnt++; if (lo !== 32'd14) $display("FAIL divu_lo: got %h exp 0000000e", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'd2) $display("FAIL divu_hi: got %h exp 00000002", hi); else pass_cnt++;
    tick();
  endtask

  task automatic test_divzero();
    int cyc, gaps;
    hi_we = 1'b1; wdata = 32'h11; tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22; tick();
    lo_we = 1'b0;
    total_cnt++; if (hi !== 32'h11) $display("FAIL mthi: got %h exp 00000011", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h22) $display("FAIL mtlo: got %h exp 00000022", lo); else pass_cnt++;
    do_start(2'b11, 32'd7, 32'd0);
    total_cnt++; if (busy !== 1'b1) $display("FAIL dz_busy_c1: got %b exp 1", busy); else pass_cnt++;
    wait_done(1, cyc, gaps);
    total_cnt++; if (cyc !== 2) $display("FAIL dz_latency: got %0d exp 2", cyc); else pass_cnt++;
    total_cnt++; if (dz !== 1'b1) $display("FAIL dz_flag: got %b exp 1", dz); else pass_cnt++;
    total_cnt++; if (hi !== 32'h11) $display("FAIL dz_hi: got %h exp 00000011", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h22) $display("FAIL dz_lo: got %h exp 00000022", lo); else pass_cnt++;
    tick();
    total_cnt++; if (dz !== 1'b1) $display("FAIL dz_hold: got %b exp 1", dz); else pass_cnt++;
    do_start(2'b01, 32'd2, 32'd3);
    wait_done(1, cyc, gaps);
    total_cnt++; if (hi !== 32'h0) $display("FAIL after_dz_hi: got %h exp 00000000", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'd6) $display("FAIL after_dz_lo: got %h exp 00000006", lo); else pass_cnt++;
    total_cnt++; if (dz !== 1'b0) $display("FAIL after_dz_dz: got %b exp 0", dz); else pass_cnt++;
    tick();
  endtask

  task automatic test_flush();
    int seen;
    do_start(2'b00, 32'd5, 32'd7);
    for (int i = 1; i < 10; i++) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b exp 0", busy); else pass_cnt++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      tick();
    end
    total_cnt++; if (seen !== 0) $display("FAIL flush_no_done: got %0d done pulses exp 0", seen); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0) $display("FAIL flush_hi: got %h exp 00000000", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'd6) $display("FAIL flush_lo: got %h exp 00000006", lo); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_start(2'b00, 32'd5, 32'd7);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (lo !== 32'h0) $display("FAIL rstmid_lo: got %h exp 00000000", lo); else pass_cnt++;
    total_cnt++; if ({done, dz, hi} !== 34'h0) $display("FAIL rstmid_other: got %h exp 0", {done, dz, hi}); else pass_cnt++;
    #2;
    rst_n = 1'b1;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_idle: got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_busy_rules();
    int cyc, gaps, seen;
    do_start(2'b11, 32'd100, 32'd7);
    for (int i = 1; i < 5; i++) tick();
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    hi_we = 1'b1; wdata = 32'hDEAD;
    tick();
    start = 1'b0; hi_we = 1'b0;
    total_cnt++; if (hi !== 32'h0) $display("FAIL busy_hi_we: got %h exp 00000000", hi); else pass_cnt++;
    wait_done(6, cyc, gaps);
    total_cnt++; if (cyc !== 34) $display("FAIL busy_latency: got %0d exp 34", cyc); else pass_cnt++;
    total_cnt++; if (lo !== 32'd14) $display("FAIL busy_lo: got %h exp 0000000e", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'd2) $display("FAIL busy_hi: got %h exp 00000002", hi); else pass_cnt++;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy || done) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL busy_no_queue: got %0d active cycles exp 0", seen); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] xa[3], xb[3], ehi[3], elo[3];
    int cyc, gaps;
    xa[0] = 32'd10;       xb[0] = 32'd20;       ehi[0] = 32'd0; elo[0] = 32'd200;
    xa[1] = 32'h00010000; xb[1] = 32'h00010000; ehi[1] = 32'd1; elo[1] = 32'd0;
    xa[2] = 32'hFFFFFFFF; xb[2] = 32'd2;        ehi[2] = 32'd1; elo[2] = 32'hFFFFFFFE;
    op = 2'b01; a = xa[0]; b = xb[0]; start = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      wait_done(1, cyc, gaps);
      total_cnt++; if (cyc !== 34) $display("FAIL b2b_latency_%0d: got %0d exp 34", k, cyc); else pass_cnt++;
      total_cnt++; if (hi !== ehi[k]) $display("FAIL b2b_hi_%0d: got %h exp %h", k, hi, ehi[k]); else pass_cnt++;
      total_cnt++; if (lo !== elo[k]) $display("FAIL b2b_lo_%0d: got %h exp %h", k, lo, elo[k]); else pass_cnt++;
      if (k < 2) begin
        a = xa[k+1]; b = xb[k+1];
      end else begin
        start = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick(); tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_mult();
    test_multu();
    test_div();
    test_divzero();
    test_flush();
    test_reset_mid();
    test_busy_rules();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
